// File: rtl/bios_loader.sv
// Stages the HPS ioctl byte stream into two 64-word ping-pong banks and hands them to the
// Next186 BIOS_REQ pull port. Define BIOS_LOADER_CHECKSUM_EN to add the `checksum` output.
module bios_loader #(
  parameter logic [7:0] INDEX     = 8'd0,
  parameter int         MAX_WORDS = 8192
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [15:0] ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        bios_req,
  output logic [12:0] bios_addr,
  output logic [15:0] bios_din,
  output logic        bios_wr,
  output logic        bios_loaded
`ifdef BIOS_LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, OFFER, STREAM, DONE} state_t;

  localparam logic [23:0] MAX_W = 24'(MAX_WORDS);

  state_t      state, state_nxt;
  logic        dl_d, active, pending, part, fill, drain, eod, req_d;
  logic [7:0]  low_byte;
  logic [5:0]  low_idx;
  logic [1:0]  full;
  logic [6:0]  cnt [2];
  logic [6:0]  rd;
  logic [12:0] waddr;
  logic [15:0] mem [128];

  logic        dl_start, dl_end, byte_ok, odd_wr, flush, we, bank_done;
  logic [5:0]  widx;
  logic [15:0] wdata;
  logic        rd_fire, blk_release, wr_nxt, loaded_nxt;
  logic        unused_index_hi;

  assign unused_index_hi = ^ioctl_index[15:8];

  assign dl_start  = ioctl_download & ~dl_d & (ioctl_index[7:0] == INDEX);
  assign dl_end    = ~ioctl_download & dl_d & active;
  // Bytes aimed at a bank still waiting to be drained are dropped; the HPS is stalled then.
  assign byte_ok   = ioctl_wr & ioctl_download & active & (ioctl_addr[24:1] < MAX_W) & ~full[fill];
  assign odd_wr    = byte_ok & ioctl_addr[0];
  assign flush     = dl_end & pending;
  assign we        = odd_wr | flush;
  assign widx      = odd_wr ? ioctl_addr[6:1] : low_idx;
  assign wdata     = odd_wr ? {ioctl_dout, low_byte} : {8'hFF, low_byte};
  assign bank_done = (odd_wr & (ioctl_addr[6:1] == 6'd63)) | (dl_end & (pending | part));
  assign ioctl_wait = full[fill] & ioctl_download & active;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   state_nxt = IDLE;
      OFFER:  if (bios_wr && bios_req)          state_nxt = STREAM;
              else if (full == 2'b00 && eod)    state_nxt = DONE;
      STREAM: if (req_d && !bios_req)           state_nxt = OFFER;
      DONE:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (dl_start) state_nxt = OFFER;
  end

  always_comb begin
    rd_fire     = bios_req & (((state == OFFER) & bios_wr) | (state == STREAM));
    blk_release = (state == STREAM) & req_d & ~bios_req;
    wr_nxt      = bios_wr;
    if (dl_start || blk_release) wr_nxt = 1'b0;
    else if (state == OFFER)     wr_nxt = full[drain];
    loaded_nxt  = (state == DONE) & ~dl_start;
  end

  always_ff @(posedge clk_sys) begin
    if (we) mem[{fill, widx}] <= wdata;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_d        <= 1'b0;
      active      <= 1'b0;
      pending     <= 1'b0;
      part        <= 1'b0;
      fill        <= 1'b0;
      drain       <= 1'b0;
      eod         <= 1'b0;
      req_d       <= 1'b0;
      low_byte    <= 8'd0;
      low_idx     <= 6'd0;
      full        <= 2'b00;
      cnt[0]      <= 7'd0;
      cnt[1]      <= 7'd0;
      rd          <= 7'd0;
      waddr       <= 13'd0;
      bios_addr   <= 13'd0;
      bios_din    <= 16'd0;
      bios_wr     <= 1'b0;
      bios_loaded <= 1'b0;
    end else begin
      dl_d        <= ioctl_download;
      req_d       <= bios_req;
      bios_wr     <= wr_nxt;
      bios_loaded <= loaded_nxt;
      if (dl_start) begin
        full      <= 2'b00;
        fill      <= 1'b0;
        drain     <= 1'b0;
        waddr     <= 13'd0;
        bios_addr <= 13'd0;
        eod       <= 1'b0;
        active    <= 1'b1;
        pending   <= 1'b0;
        part      <= 1'b0;
        rd        <= 7'd0;
      end else begin
        if (dl_end) begin
          active  <= 1'b0;
          eod     <= 1'b1;
          pending <= 1'b0;
          part    <= 1'b0;
        end
        if (byte_ok && !ioctl_addr[0]) begin
          low_byte <= ioctl_dout;
          low_idx  <= ioctl_addr[6:1];
          pending  <= 1'b1;
        end
        if (we) cnt[fill] <= {1'b0, widx} + 7'd1;
        if (odd_wr) begin
          pending <= 1'b0;
          part    <= (ioctl_addr[6:1] != 6'd63);
        end
        // Words past the last one written into this bank read back as erased flash.
        if (rd_fire) begin
          bios_din  <= (rd >= cnt[drain]) ? 16'hFFFF : mem[{drain, rd[5:0]}];
          bios_addr <= waddr;
          waddr     <= waddr + 13'd1;
          rd        <= rd + 7'd1;
        end
        if (blk_release) begin
          full[drain] <= 1'b0;
          drain       <= ~drain;
          rd          <= 7'd0;
        end
        if (bank_done) begin
          full[fill] <= 1'b1;
          fill       <= ~fill;
        end
      end
    end
  end

`ifdef BIOS_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                    checksum <= 16'd0;
    else if (dl_start)               checksum <= 16'd0;
    else if (we && state != DONE)    checksum <= checksum + wdata;
  end
`endif

endmodule

// File: tb/tb_bios_loader.sv
// Self-checking bench for bios_loader: acts as both the HPS downloader and the Next186 puller,
// comparing every delivered word against a byte-image reference model.
module tb_bios_loader;

  logic        clk_sys;
  logic        reset_n;
  logic        ioctl_download;
  logic [15:0] ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        bios_req;
  logic [12:0] bios_addr;
  logic [15:0] bios_din;
  logic        bios_wr;
  logic        bios_loaded;
`ifdef BIOS_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int          assertCount = 0;
  int          failCount   = 0;
  int          sentCount   = 0;
  int          imgLen      = 0;
  logic [7:0]  img [0:1023];

  bios_loader dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .bios_req       (bios_req),
    .bios_addr      (bios_addr),
    .bios_din       (bios_din),
    .bios_wr        (bios_wr),
    .bios_loaded    (bios_loaded)
`ifdef BIOS_LOADER_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: word w is bytes 2w/2w+1 of the image, a missing odd byte reads FF, beyond the image FFFF.
  function automatic logic [15:0] expWord(input int w);
    logic [7:0] hi;
    if (2 * w >= imgLen) return 16'hFFFF;
    hi = (2 * w + 1 < imgLen) ? img[2 * w + 1] : 8'hFF;
    return {hi, img[2 * w]};
  endfunction

  function automatic logic [15:0] expSum();
    logic [15:0] s = 16'd0;
    for (int w = 0; w < (imgLen + 1) / 2; w++) s = s + expWord(w);
    return s;
  endfunction

  task automatic fillImage(input int n, input bit ramp);
    imgLen = n;
    for (int i = 0; i < n; i++) img[i] = ramp ? 8'(i) : 8'($urandom);
  endtask

  task automatic startDownload(input logic [7:0] idx);
    ioctl_index    = {8'h00, idx};
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  // HPS side: sends n bytes, honouring ioctl_wait, with random idle gaps.
  task automatic applyStimulus(input int n, input int gapMax, input bit drop);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (ioctl_wait && t < 20000) begin
        @(negedge clk_sys);
        t++;
      end
      if (t >= 20000) begin
        checkOutput("hps_wait_timeout", 32'(ioctl_wait), 32'd0);
        break;
      end
      ioctl_addr = 25'(i);
      ioctl_dout = img[i];
      ioctl_wr   = 1'b1;
      sentCount++;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      repeat ($urandom_range(0, gapMax)) @(negedge clk_sys);
    end
    if (drop) begin
      ioctl_download = 1'b0;
      @(negedge clk_sys);
    end
  endtask

  task automatic pullWords(input int first, input int count, input bit keepReq);
    for (int k = 0; k < count; k++) begin
      bios_req = 1'b1;
      @(negedge clk_sys);
      checkOutput("bios_addr", 32'(bios_addr), 32'((first + k) % 8192));
      checkOutput("bios_din", 32'(bios_din), 32'(expWord(first + k)));
    end
    if (!keepReq) begin
      bios_req = 1'b0;
      @(negedge clk_sys);
      checkOutput("wr_drop", 32'(bios_wr), 32'd0);
    end
  endtask

  task automatic waitOffer();
    int t = 0;
    while (!bios_wr && t < 5000) begin
      @(negedge clk_sys);
      t++;
    end
    if (t >= 5000) checkOutput("wr_timeout", 32'(bios_wr), 32'd1);
  endtask

  // System side: drains every block of an n-byte image, optionally stalling until the HPS is throttled.
  task automatic drainImage(input int n, input bit stallFirst);
    int blocks = (((n + 1) / 2) + 63) / 64;
    int t = 0;
    if (stallFirst) begin
      while (!ioctl_wait && t < 5000) begin
        @(negedge clk_sys);
        t++;
      end
      checkOutput("wait_rise", 32'(ioctl_wait), 32'd1);
      checkOutput("bytes_before_wait", 32'(sentCount), 32'd256);
      repeat (5) @(negedge clk_sys);
      checkOutput("wait_hold", 32'(ioctl_wait), 32'd1);
      checkOutput("bytes_held", 32'(sentCount), 32'd256);
    end
    for (int b = 0; b < blocks; b++) begin
      waitOffer();
      repeat ($urandom_range(0, 3)) @(negedge clk_sys);
      pullWords(b * 64, 64, 1'b0);
      if (stallFirst && b == 0) checkOutput("wait_release", 32'(ioctl_wait), 32'd0);
    end
    t = 0;
    while (!bios_loaded && t < 20) begin
      @(negedge clk_sys);
      t++;
    end
    checkOutput("loaded", 32'(bios_loaded), 32'd1);
    checkOutput("wr_idle", 32'(bios_wr), 32'd0);
  endtask

  task automatic runImage(input int n, input bit stall, input int gapMax);
    startDownload(8'd0);
    sentCount = 0;
    fork
      applyStimulus(n, gapMax, 1'b1);
      drainImage(n, stall);
    join
`ifdef BIOS_LOADER_CHECKSUM_EN
    checkOutput("checksum", 32'(checksum), 32'(expSum()));
`endif
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_wait"},   32'(ioctl_wait),  32'd0);
    checkOutput({tag, "_addr"},   32'(bios_addr),   32'd0);
    checkOutput({tag, "_din"},    32'(bios_din),    32'd0);
    checkOutput({tag, "_wr"},     32'(bios_wr),     32'd0);
    checkOutput({tag, "_loaded"}, 32'(bios_loaded), 32'd0);
  endtask

  initial begin
    bit sawWr, sawWait, sawLoaded;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 16'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 25'd0;
    ioctl_dout     = 8'd0;
    bios_req       = 1'b0;
    repeat (3) @(negedge clk_sys);
    checkResetOutputs("reset");
    reset_n = 1'b1;
    @(negedge clk_sys);

    $display("[TB] foreign index download");
    fillImage(200, 1'b0);
    sawWr = 0; sawWait = 0; sawLoaded = 0;
    startDownload(8'd3);
    fork
      applyStimulus(200, 1, 1'b1);
      for (int c = 0; c < 700; c++) begin
        @(negedge clk_sys);
        if (bios_wr)     sawWr = 1;
        if (ioctl_wait)  sawWait = 1;
        if (bios_loaded) sawLoaded = 1;
      end
    join
    checkOutput("idx_wr", 32'(sawWr), 32'd0);
    checkOutput("idx_wait", 32'(sawWait), 32'd0);
    checkOutput("idx_loaded", 32'(sawLoaded), 32'd0);

    $display("[TB] 128-byte ramp image");
    fillImage(128, 1'b1);
    runImage(128, 1'b0, 2);

    $display("[TB] 300-byte image, stalled system");
    fillImage(300, 1'b0);
    runImage(300, 1'b1, 1);

    $display("[TB] 129-byte ramp image");
    fillImage(129, 1'b1);
    checkOutput("model_w64", 32'(expWord(64)), 32'h0000FF80);
    runImage(129, 1'b0, 0);

    for (int r = 0; r < 3; r++) begin
      int n = $urandom_range(1, 400);
      $display("[TB] random image of %0d bytes", n);
      fillImage(n, 1'b0);
      runImage(n, 1'b0, $urandom_range(0, 3));
    end

    $display("[TB] restart during STREAM");
    fillImage(128, 1'b0);
    startDownload(8'd0);
    applyStimulus(128, 1, 1'b1);
    waitOffer();
    pullWords(0, 10, 1'b1);
    fillImage(100, 1'b0);
    ioctl_index    = 16'd0;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    checkOutput("restart_addr", 32'(bios_addr), 32'd0);
    checkOutput("restart_loaded", 32'(bios_loaded), 32'd0);
    checkOutput("restart_wr", 32'(bios_wr), 32'd0);
    bios_req = 1'b0;
    @(negedge clk_sys);
    sentCount = 0;
    fork
      applyStimulus(100, 2, 1'b1);
      drainImage(100, 1'b0);
    join

`ifdef BIOS_LOADER_CHECKSUM_EN
    $display("[TB] 4-byte checksum image");
    imgLen = 4;
    img[0] = 8'h01; img[1] = 8'h00; img[2] = 8'h02; img[3] = 8'h00;
    runImage(4, 1'b0, 0);
    checkOutput("checksum_4b", 32'(checksum), 32'h0003);
`endif

    $display("[TB] asynchronous reset mid-transfer");
    fillImage(130, 1'b0);
    startDownload(8'd0);
    applyStimulus(130, 0, 1'b0);
    waitOffer();
    pullWords(0, 3, 1'b1);
    #2 reset_n = 1'b0;
    #1 checkResetOutputs("async_reset");
`ifdef BIOS_LOADER_CHECKSUM_EN
    checkOutput("async_reset_checksum", 32'(checksum), 32'd0);
`endif
    bios_req       = 1'b0;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    $display("[TB] recovery image after reset");
    fillImage(50, 1'b0);
    runImage(50, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
